// File: rtl/gtx_rx_link.sv
// GTX receive deframer: aligns to comma-led, checksummed, sequence-numbered
// frames and extracts CH_NUM channel bits, with hunt/check/lock tracking.

module gtx_rx_link_lane #(
  parameter int LW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cap_i,
  input  logic [LW-1:0] din_i,
  output logic [LW-1:0] dout_o
);
  always_ff @(posedge clk_i) begin
    if (rst_i)      dout_o <= '0;
    else if (cap_i) dout_o <= din_i;
  end
endmodule

module gtx_rx_link #(
  parameter int                CH_NUM   = 2,
  parameter int                LOCK_CNT = 3,
  parameter int                LOSS_CNT = 4,
  parameter int                TIMEOUT  = 1024,
  parameter logic [CH_NUM-1:0] SAFE_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        ctrl_i,
  input  logic [15:0]       data_i,
  output logic [CH_NUM-1:0] data_o,
  output logic              valid_o,
  output logic              lock_o,
  output logic              err_o,
  output logic [15:0]       err_cnt_o
);
  localparam int W  = (CH_NUM + 15) / 16;
  localparam int PW = $clog2(W + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] LAST     = PW'(W + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0]    LOSS_C   = 4'(LOSS_CNT);

  typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     pos, pos_n;
  logic              skip, skip_n;
  logic [15:0]       chk, chk_n;
  logic [7:0]        cur_seq, cur_seq_n, prev_seq, prev_seq_n;
  logic              seq_vld, seq_vld_n;
  logic [3:0]        good_cnt, good_n, bad_cnt, bad_n;
  logic [TW-1:0]     tmo_cnt, tmo_n;
  logic [15:0]       err_cnt_n;
  logic [CH_NUM-1:0] data_n, pay;
  logic              is_comma, seq_ok, frm_good, frm_bad, f_start, uc, pay_cap;
  logic              tmo_hit, enter_hunt, upd, err_n;

  // One capture register per payload word; the last lane keeps only the
  // channel bits it actually carries.
  for (genvar i = 0; i < W; i++) begin : g_lane
    localparam int LW = (CH_NUM - 16*i) >= 16 ? 16 : CH_NUM - 16*i;
    gtx_rx_link_lane #(.LW(LW)) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .cap_i  (pay_cap && (pos == PW'(i + 1))),
      .din_i  (data_i[LW-1:0]),
      .dout_o (pay[16*i +: LW])
    );
  end

  always_comb begin
    is_comma = (ctrl_i == 2'b01) && (data_i[7:0] == 8'hBC);
    seq_ok   = !seq_vld || (data_i[15:8] == prev_seq + 8'd1);
    frm_good = 1'b0;
    frm_bad  = 1'b0;
    f_start  = 1'b0;
    uc       = 1'b0;
    pay_cap  = 1'b0;
    pos_n    = pos;
    skip_n   = skip;
    chk_n    = chk;

    // Frame parser: a bad frame either discards to the next comma (skip)
    // or, for an unexpected comma, restarts on that comma.
    if (state == HUNT) begin
      f_start = is_comma;
    end else if (skip) begin
      if (is_comma) begin
        f_start = seq_ok;
        frm_bad = !seq_ok;
      end
    end else if (pos == '0) begin
      if (is_comma && seq_ok) f_start = 1'b1;
      else begin
        frm_bad = 1'b1;
        skip_n  = 1'b1;
      end
    end else if (is_comma) begin
      frm_bad = 1'b1;
      uc      = 1'b1;
      f_start = seq_ok;
      skip_n  = !seq_ok;
    end else if (ctrl_i != 2'b00) begin
      frm_bad = 1'b1;
      skip_n  = 1'b1;
    end else if (pos != LAST) begin
      chk_n   = chk ^ data_i;
      pay_cap = 1'b1;
      pos_n   = pos + PW'(1);
    end else if (data_i == chk) begin
      frm_good = 1'b1;
      pos_n    = '0;
    end else begin
      frm_bad = 1'b1;
      skip_n  = 1'b1;
    end
    if (f_start) begin
      pos_n  = PW'(1);
      chk_n  = '0;
      skip_n = 1'b0;
    end
    cur_seq_n = f_start ? data_i[15:8] : cur_seq;

    state_n    = state;
    good_n     = good_cnt;
    bad_n      = bad_cnt;
    prev_seq_n = prev_seq;
    seq_vld_n  = seq_vld;
    err_cnt_n  = err_cnt_o;
    err_n      = 1'b0;
    upd        = 1'b0;
    enter_hunt = 1'b0;
    tmo_n      = (state == HUNT) ? '0 : tmo_cnt + TW'(1);
    tmo_hit    = (state != HUNT) && (tmo_cnt == TMO_LAST) && !frm_good;

    case (state)
      HUNT: if (is_comma) begin
        state_n   = CHECK;
        good_n    = '0;
        seq_vld_n = 1'b0;
      end
      CHECK: begin
        if (frm_good) begin
          good_n = good_cnt + 4'd1;
          if (good_cnt + 4'd1 == LOCK_C) begin
            state_n = LOCK;
            upd     = 1'b1;
            bad_n   = '0;
          end
        end else if (frm_bad) begin
          err_n      = 1'b1;
          enter_hunt = 1'b1;
        end
      end
      LOCK: begin
        if (frm_good) begin
          upd   = 1'b1;
          bad_n = '0;
        end else if (frm_bad) begin
          err_n = 1'b1;
          if (err_cnt_o != 16'hFFFF) err_cnt_n = err_cnt_o + 16'd1;
          bad_n = bad_cnt + 4'd1;
          if (bad_cnt + 4'd1 == LOSS_C) enter_hunt = 1'b1;
        end
      end
      default: state_n = HUNT;
    endcase

    if (frm_good) begin
      prev_seq_n = cur_seq;
      seq_vld_n  = 1'b1;
      tmo_n      = '0;
    end
    if (tmo_hit) enter_hunt = 1'b1;
    // A restarting comma passes through HUNT straight into a fresh CHECK.
    if (enter_hunt) begin
      bad_n = '0;
      if (uc && f_start) begin
        state_n   = CHECK;
        good_n    = '0;
        seq_vld_n = 1'b0;
        tmo_n     = '0;
      end else begin
        state_n = HUNT;
        pos_n   = '0;
        skip_n  = 1'b0;
      end
    end
    data_n = enter_hunt ? SAFE_VAL : (upd ? pay : data_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= HUNT;
      pos       <= '0;
      skip      <= 1'b0;
      chk       <= '0;
      cur_seq   <= '0;
      prev_seq  <= '0;
      seq_vld   <= 1'b0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      tmo_cnt   <= '0;
      err_cnt_o <= '0;
      data_o    <= SAFE_VAL;
      valid_o   <= 1'b0;
      lock_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state     <= state_n;
      pos       <= pos_n;
      skip      <= skip_n;
      chk       <= chk_n;
      cur_seq   <= cur_seq_n;
      prev_seq  <= prev_seq_n;
      seq_vld   <= seq_vld_n;
      good_cnt  <= good_n;
      bad_cnt   <= bad_n;
      tmo_cnt   <= tmo_n;
      err_cnt_o <= err_cnt_n;
      data_o    <= data_n;
      valid_o   <= upd;
      lock_o    <= (state_n == LOCK);
      err_o     <= err_n;
    end
  end
endmodule
